// File: rtl/rr_grant_sequencer_8.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_sequencer_8
// Description : Eight-requester round-robin arbiter. Presents the granted
//               index as a 3-bit code on x (MSB), y, z with a valid qualifier,
//               holds the grant until done, then advances priority past the
//               granted index.
//               Optional macro RR_TIMEOUT_EN adds a grant-hold limit of
//               TIMEOUT cycles with a one-cycle timeout pulse on forced
//               release.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_sequencer_8 #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last counter value before a forced release.
    localparam logic [7:0] HOLD_LIMIT = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] idx;
    logic [2:0] idx_nxt;
    logic [2:0] ptr;
    logic [2:0] ptr_nxt;
    logic       found;
    logic [2:0] pick;
    logic [2:0] cand;

`ifdef RR_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic [7:0] hold_nxt;
    logic       timeout_q;
    logic       timeout_nxt;
`endif

    // Wrapped priority search: first set request at or above ptr.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = ptr;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, hold in GRANT until release.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ptr_nxt   = ptr;
`ifdef RR_TIMEOUT_EN
        hold_nxt    = hold_cnt;
        timeout_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    idx_nxt   = pick;
                    state_nxt = GRANT;
`ifdef RR_TIMEOUT_EN
                    hold_nxt  = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (done) begin
                    state_nxt = IDLE;
                    ptr_nxt   = idx + 3'd1;
                end
`ifdef RR_TIMEOUT_EN
                else if (hold_cnt == HOLD_LIMIT) begin
                    state_nxt   = IDLE;
                    ptr_nxt     = idx + 3'd1;
                    timeout_nxt = 1'b1;
                end else begin
                    hold_nxt = hold_cnt + 8'd1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; reset overrides any in-flight grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= 3'd0;
            ptr   <= 3'd0;
`ifdef RR_TIMEOUT_EN
            hold_cnt  <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            ptr   <= ptr_nxt;
`ifdef RR_TIMEOUT_EN
            hold_cnt  <= hold_nxt;
            timeout_q <= timeout_nxt;
`endif
        end
    end

    assign {x, y, z} = idx;
    assign valid     = (state == GRANT);

`ifdef RR_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    // No hold limit: timeout is tied low (expression keeps HOLD_LIMIT referenced).
    assign timeout = (HOLD_LIMIT == 8'd0) & 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_sequencer_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_grant_sequencer_8
// Description : Self-checking bench for rr_grant_sequencer_8 with directed
//               steps followed by random traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_grant_sequencer_8;

`ifdef RR_TIMEOUT_EN
    localparam int TIMEOUT = 4;
`else
    localparam int TIMEOUT = 16;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       done;
    logic       x, y, z, valid, timeout;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit m_busy;
    int m_idx;
    int m_ptr;
    int m_age;
    bit m_to;

    rr_grant_sequencer_8 #(.TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .x       (x),
        .y       (y),
        .z       (z),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model over the edge, then check.
    task automatic step(input logic r, input logic [7:0] rq, input logic d);
        reset = r;
        req   = rq;
        done  = d;
        @(posedge clk);
        m_to = 1'b0;
        if (r) begin
            m_busy = 1'b0;
            m_idx  = 0;
            m_ptr  = 0;
            m_age  = 0;
        end else if (m_busy) begin
            m_age++;
            if (d) begin
                m_busy = 1'b0;
                m_ptr  = (m_idx + 1) % 8;
            end
`ifdef RR_TIMEOUT_EN
            else if (m_age == TIMEOUT) begin
                m_busy = 1'b0;
                m_ptr  = (m_idx + 1) % 8;
                m_to   = 1'b1;
            end
`endif
        end else if (rq != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
                if (!m_busy && rq[(m_ptr + k) % 8]) begin
                    m_busy = 1'b1;
                    m_idx  = (m_ptr + k) % 8;
                    m_age  = 0;
                end
            end
        end
        #1;
        check("model_valid", int'(valid), int'(m_busy));
        check("model_xyz", int'({x, y, z}), m_idx);
        check("model_timeout", int'(timeout), int'(m_to));
    endtask

    initial begin
        reset = 1'b1;
        req   = 8'hFF;
        done  = 1'b0;
        m_busy = 1'b0; m_idx = 0; m_ptr = 0; m_age = 0; m_to = 1'b0;

        // Reset held two cycles with all requesting
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        check("reset_valid", int'(valid), 0);
        check("reset_xyz", int'({x, y, z}), 0);
        check("reset_timeout", int'(timeout), 0);

        // First grant one edge after release
        step(1'b0, 8'hFF, 1'b0);
        check("first_valid", int'(valid), 1);
        check("first_xyz", int'({x, y, z}), 0);

        // Full rotation 1..7,0 with a gap cycle between grants
        for (int g = 1; g <= 8; g++) begin
            step(1'b0, 8'hFF, 1'b1);
            check("rot_gap", int'(valid), 0);
            step(1'b0, 8'hFF, 1'b0);
            check("rot_xyz", int'({x, y, z}), g % 8);
        end

        // Ends-only requesters: 0 -> 7 -> 0 wrap
        step(1'b0, 8'h81, 1'b1);
        step(1'b0, 8'h81, 1'b0);
        check("wrap_hi", int'({x, y, z}), 7);
        step(1'b0, 8'h81, 1'b1);
        step(1'b0, 8'h81, 1'b0);
        check("wrap_lo", int'({x, y, z}), 0);

        // Grant idx 5, drop its request and hold without done
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h20, 1'b0);
        check("hold_xyz", int'({x, y, z}), 5);
`ifndef RR_TIMEOUT_EN
        for (int c = 0; c < 10; c++) step(1'b0, 8'h00, 1'b0);
        check("hold_valid", int'(valid), 1);
        check("hold_xyz_after", int'({x, y, z}), 5);
`endif
        step(1'b0, 8'h00, 1'b1);
        check("hold_release", int'(valid), 0);

        // Reset in the middle of a grant to idx 3
        step(1'b0, 8'h08, 1'b0);
        check("mid_xyz", int'({x, y, z}), 3);
        step(1'b1, 8'h00, 1'b0);
        check("mid_reset_valid", int'(valid), 0);
        check("mid_reset_xyz", int'({x, y, z}), 0);
        step(1'b0, 8'h18, 1'b0);
        check("post_reset_xyz", int'({x, y, z}), 3);

`ifdef RR_TIMEOUT_EN
        // Forced release after TIMEOUT grant cycles, then next above idx 2
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h04, 1'b0);
        check("to_grant", int'({x, y, z}), 2);
        for (int c = 1; c < TIMEOUT; c++) begin
            step(1'b0, 8'h0C, 1'b0);
            check("to_held", int'(valid), 1);
        end
        step(1'b0, 8'h0C, 1'b0);
        check("to_drop", int'(valid), 0);
        check("to_pulse", int'(timeout), 1);
        step(1'b0, 8'h0C, 1'b0);
        check("to_pulse_end", int'(timeout), 0);
        check("to_next", int'({x, y, z}), 3);
`endif

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic       r_rst;
            logic [7:0] r_req;
            logic       r_done;
            r_rst  = ($urandom_range(0, 49) == 0);
            r_req  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            r_done = ($urandom_range(0, 2) == 0);
            step(r_rst, r_req, r_done);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_grant_sequencer_8.md
Name: rr_grant_sequencer_8

Overview:
- Eight-requester round-robin arbiter/sequencer.
- Selects one requester and presents its index as a 3-bit code on x, y, z (x = MSB), qualified by valid.
- The code is produced in exactly the form the 3-to-8 one-hot decoder stage consumes. That decoder sits directly downstream and turns the code into the one-hot grant vector.
- Holds each grant until the granted requester signals done, then advances priority.

Parameters:
- TIMEOUT, 16, grant-hold limit in cycles before a forced release (used only with RR_TIMEOUT_EN; legal range 2..255).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  8  request vector; bit i = requester i
- done  input  1  granted requester finished; sampled only while valid=1
- x  output  1  grant index bit 2 (MSB)
- y  output  1  grant index bit 1
- z  output  1  grant index bit 0 (LSB)
- valid  output  1  grant code on x,y,z is live
- timeout  output  1  one-cycle pulse on forced release (tied 0 without macro)

Behaviour:
- Reset:
  - Synchronous, active-high, sampled on the rising clk edge.
  - x=y=z=0, valid=0, timeout=0, state=IDLE, priority pointer ptr=0, hold counter=0.
  - Reset wins over every other event on the same edge, including mid-grant. The grant drops on that edge and ptr returns to 0.
- State IDLE (valid=0):
  - If req != 0 on an edge, search from index ptr upward with wrap (ptr, ptr+1, ... 7, 0, ... ptr-1).
  - Register the first set bit as idx, drive {x,y,z}=idx, move to GRANT.
  - valid rises on the same edge, so latency is one cycle from req sampled to valid=1.
  - If req == 0, stay in IDLE. x,y,z hold their last value and are don't-care while valid=0.
- State GRANT (valid=1):
  - x,y,z are stable for the whole grant.
  - req changes, including the granted bit dropping, are ignored.
  - On an edge with done=1: valid<=0, ptr<=(idx+1) mod 8 (wrap 7→0), move to IDLE.
  - There is always at least one valid=0 cycle between grants.
  - done is ignored while in IDLE.
- Fairness:
  - A continuously asserting requester waits at most 7 grants.
  - With all 8 requesting, the grant order is 0,1,...,7,0,...
- Pointer arithmetic: 3-bit, natural wrap. ptr depends only on the last granted idx, never on the requester search position.
- Simultaneous events:
  - done and a new req on the same edge: release only. The new request is arbitrated from IDLE on the following edge using the updated ptr.
- No combinational path from req/done to outputs. All outputs are registered.

Optional Feature:
- Macro: RR_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on grant entry and increments each GRANT cycle without done.
  - When it reaches TIMEOUT-1 without done, the next edge forces a release: valid<=0, timeout<=1 for exactly one cycle, ptr<=idx+1, move to IDLE.
  - done on the same edge as the timeout edge counts as a normal release; timeout stays 0.
- Undefined: no counter is built, timeout is constant 0, and a grant is held indefinitely until done.

Test Plan:
- Reset held 2 cycles, req=8'hFF → valid=0, xyz=000, timeout=0. Release reset → after 1 edge valid=1, xyz=000.
- req=8'hFF held, done pulsed 1 cycle per grant → xyz sequence 000,001,...,111,000 with one valid=0 gap between each.
- req=8'b1000_0001, first grant idx 0, done → next grant xyz=111. Then done → xyz=000, confirming 7→0 wrap.
- Grant to idx 5 active, req[5] dropped to 0 with no done for 10 cycles → valid stays 1, xyz=101. Then done=1 → valid=0 on the next edge.
- Reset asserted mid-grant (idx 3) → next edge valid=0, xyz=000. After release with req=8'h18, the grant is idx 3 (ptr back to 0).
- With RR_TIMEOUT_EN, TIMEOUT=4, idx 2 granted, done never asserted → valid falls after 4 GRANT cycles, timeout pulses for 1 cycle, and the next grant goes to the next requester above 2.
